// File: rtl/video_in_to_axi4s_if.sv
// AXI4-Stream video bus between the capture block and the frame-write VDMA.
// tuser marks the first pixel of a frame, tlast the last pixel of a line.
interface video_in_to_axi4s_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  tuser;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tuser, tlast, tdata, tvalid, input tready);
  modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/video_in_to_axi4s.sv
// Sync-parallel video (vsync/de/data) to AXI4-Stream video with a show-ahead FIFO and frame drop on overflow.
// Optional VIDEO_IN_TO_AXI4S_FRAME_COUNT_EN adds a 16-bit status_frame_count output.
module video_in_to_axi4s #(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_PTR_WIDTH = 9,
  parameter bit VSYNC_POL      = 1'b1,
  parameter bit DE_POL         = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ctl_enable,
  input  logic                  ctl_clear,
  output logic                  status_busy,
  output logic                  status_overflow,
`ifdef VIDEO_IN_TO_AXI4S_FRAME_COUNT_EN
  output logic [15:0]           status_frame_count,
`endif
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic [DATA_WIDTH-1:0] in_data,
  video_in_to_axi4s_if.master   m_axi4s
);
  localparam int DEPTH  = 2 ** FIFO_PTR_WIDTH;
  localparam int WORD_W = DATA_WIDTH + 2;
  localparam logic [FIFO_PTR_WIDTH:0] FULL_CNT = (FIFO_PTR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t                    state_q;
  logic                      vsync_q, de_q, vs_act_d_q;
  logic [DATA_WIDTH-1:0]     data_q, held_data_q;
  logic                      held_valid_q, sof_pending_q, busy_q, overflow_q;
  logic [WORD_W-1:0]         mem [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR_WIDTH:0]   count_q, ram_cnt;
  logic                      out_valid_q;
  logic [WORD_W-1:0]         out_word_q, wr_word;
  logic vs_act, de_act, pix_act, vs_rise, full, wr_req, wr_en, ovf;
  logic pop, load, ram_empty, bypass, ram_wr, ram_rd;

  always_comb begin
    vs_act    = (vsync_q == VSYNC_POL);
    de_act    = (de_q == DE_POL);
    pix_act   = de_act & ~vs_act;
    vs_rise   = vs_act & ~vs_act_d_q;
    // Held pixel's tlast depends on whether its successor is a pixel; vsync forces tlast.
    wr_word   = {sof_pending_q, ~pix_act, held_data_q};
    full      = (count_q == FULL_CNT);
    wr_req    = held_valid_q & (state_q == ACTIVE);
    wr_en     = wr_req & ~full;
    ovf       = wr_req & full;
    pop       = out_valid_q & m_axi4s.tready;
    load      = ~out_valid_q | pop;
    ram_cnt   = count_q - (FIFO_PTR_WIDTH + 1)'(out_valid_q);
    ram_empty = (ram_cnt == '0);
    // With nothing queued in RAM, a new word goes straight to the output register.
    bypass    = load & ram_empty & wr_en;
    ram_wr    = wr_en & ~bypass;
    ram_rd    = load & ~ram_empty;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      sof_pending_q <= 1'b0;
      held_valid_q  <= 1'b0;
      held_data_q   <= '0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      data_q        <= '0;
      vs_act_d_q    <= 1'b0;
    end else begin
      vsync_q      <= in_vsync;
      de_q         <= in_de;
      data_q       <= in_data;
      vs_act_d_q   <= vs_act;
      held_valid_q <= pix_act & (state_q == ACTIVE) & ~ovf;
      if (pix_act) held_data_q <= data_q;
      if (vs_rise) sof_pending_q <= 1'b1;
      else if (wr_en) sof_pending_q <= 1'b0;
      if (ovf) overflow_q <= 1'b1;
      else if (ctl_clear) overflow_q <= 1'b0;
      case (state_q)
        IDLE: if (vs_rise && ctl_enable) begin
          state_q <= ACTIVE;
          busy_q  <= 1'b1;
        end
        ACTIVE, DROP: if (vs_rise) begin
          state_q <= ctl_enable ? ACTIVE : IDLE;
          busy_q  <= ctl_enable;
        end else if (ovf) begin
          state_q <= DROP;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (ram_wr) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      count_q <= count_q + (FIFO_PTR_WIDTH + 1)'(wr_en) - (FIFO_PTR_WIDTH + 1)'(pop);
      if (ram_wr) wr_ptr_q <= wr_ptr_q + FIFO_PTR_WIDTH'(1);
      if (ram_rd) rd_ptr_q <= rd_ptr_q + FIFO_PTR_WIDTH'(1);
      if (load) begin
        if (!ram_empty) begin
          out_word_q  <= mem[rd_ptr_q];
          out_valid_q <= 1'b1;
        end else if (wr_en) begin
          out_word_q  <= wr_word;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef VIDEO_IN_TO_AXI4S_FRAME_COUNT_EN
  logic [15:0] frame_count_q;
  always_ff @(posedge aclk) begin
    if (!aresetn) frame_count_q <= '0;
    else if (vs_rise && ctl_enable) frame_count_q <= frame_count_q + 16'd1;
  end
  assign status_frame_count = frame_count_q;
`endif

  assign status_busy     = busy_q;
  assign status_overflow = overflow_q;
  assign m_axi4s.tvalid  = out_valid_q;
  assign m_axi4s.tuser   = out_word_q[WORD_W-1];
  assign m_axi4s.tlast   = out_word_q[WORD_W-2];
  assign m_axi4s.tdata   = out_word_q[DATA_WIDTH-1:0];
endmodule
